// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low patterns (bit6=g .. bit0=a),
// digit kind encodings and scan FSM states.
package seg_pkg;

    typedef enum logic [1:0] {
        KIND_BLANK = 2'b00,
        KIND_HEX   = 2'b01,
        KIND_DASH  = 2'b10,
        KIND_INV   = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

    typedef struct packed {
        kind_e      kind;
        logic [3:0] value;
    } seg_dec_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] HEX_PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // True when exactly one active-low anode is driven.
    function automatic logic an_onehot(input logic [3:0] an);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 4; i++)
            if (!an[i]) zeros++;
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low segment pattern into kind and value.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [1:0] kind,
    output logic [3:0] value
);

    seg_dec_t dec;

    always_comb begin
        dec.kind  = KIND_INV;
        dec.value = 4'd0;
        if (seg == SEG_BLANK) begin
            dec.kind = KIND_BLANK;
        end else if (seg == SEG_DASH) begin
            dec.kind = KIND_DASH;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg == HEX_PAT[i]) begin
                    dec.kind  = KIND_HEX;
                    dec.value = 4'(i);
                end
            end
        end
    end

    assign kind  = dec.kind;
    assign value = dec.value;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: synchronises seg/an, waits for
// each digit to settle, decodes it into per-digit registers and flags frames/idle.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits_o,
    output logic [7:0]  kind_o,
    output logic        frame_o,
    output logic        idle_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0][10:0] sync_pipe;
    logic [10:0]      cur, prev;
    logic [CW-1:0]    stab_cnt;
    logic [TW-1:0]    tmo_cnt, tmo_cnt_d;
    logic [3:0]       seen_q, seen_nx;
    state_e           state_q, state_d;
    logic             change, settled, an_ok, capture;
    logic [1:0]       idx;
    logic [1:0]       dec_kind;
    logic [3:0]       dec_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe <= '1;
            prev      <= '1;
        end else begin
            sync_pipe[0] <= {an_in, seg_in};
            sync_pipe[1] <= sync_pipe[0];
            prev         <= sync_pipe[1];
        end
    end

    assign cur    = sync_pipe[1];
    assign change = (cur != prev);
    assign an_ok  = an_onehot(cur[10:7]);
    // cur has already held for one cycle by the time it matches prev, so the
    // window closes one count early; >= also covers a HOLD->WAIT->SETTLE re-entry.
    assign settled = !change && (stab_cnt >= CW'(STABLE_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stab_cnt <= '0;
        else if (change)
            stab_cnt <= '0;
        else if (stab_cnt != CW'(STABLE_CYCLES))
            stab_cnt <= stab_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_WAIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (an_ok) begin
                    if (settled) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!an_ok) begin
                    state_d = ST_WAIT;
                end else if (settled) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (change) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!cur[7+i]) idx = 2'(i);
    end

    seg_pattern_decode u_dec (
        .seg   (cur[6:0]),
        .kind  (dec_kind),
        .value (dec_value)
    );

    assign seen_nx = seen_q | (4'b0001 << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o <= '0;
            kind_o   <= '0;
            seen_q   <= '0;
            frame_o  <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (capture) begin
                digits_o[4*idx +: 4] <= dec_value;
                kind_o[2*idx +: 2]   <= dec_kind;
                if (seen_nx == 4'b1111) begin
                    frame_o <= 1'b1;
                    seen_q  <= '0;
                end else begin
                    seen_q  <= seen_nx;
                end
            end
        end
    end

    always_comb begin
        if (capture)
            tmo_cnt_d = '0;
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES))
            tmo_cnt_d = tmo_cnt;
        else
            tmo_cnt_d = tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            idle_o  <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_d;
            idle_o  <= !capture && (tmo_cnt_d == TW'(TIMEOUT_CYCLES));
        end
    end

endmodule
